// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready execution wrapper around the RV32I ADD/SUB/AND/OR/SLT set.
// S1 holds the accepted request; S2 holds the computed response and drives every out_* port.
module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_ctrl,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_carry,
  output logic               out_overflow,
  output logic               out_zero,
  output logic               out_negative,
  output logic               out_illegal,
  output logic [TAG_W-1:0]   out_tag,
  output logic [COUNT_W-1:0] op_count
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic               s1_valid_q;
  logic [WIDTH-1:0]   s1_a_q, s1_b_q;
  logic [2:0]         s1_ctrl_q;
  logic [TAG_W-1:0]   s1_tag_q;

  logic               s2_valid_q;
  logic [WIDTH-1:0]   s2_result_q;
  logic               s2_carry_q, s2_overflow_q, s2_zero_q, s2_negative_q, s2_illegal_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic [COUNT_W-1:0] op_count_q;

  logic               s2_adv, accept, pop;
  logic [WIDTH:0]     sum, diff;
  logic               ovf_add, ovf_sub;
  logic [WIDTH-1:0]   result_d;
  logic               carry_d, overflow_d, illegal_d;

  // S1 may refill on the same edge it hands its op to S2.
  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign accept   = in_valid & in_ready;
  assign pop      = s2_valid_q & out_ready;

  assign sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign diff    = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) & (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
  assign ovf_sub = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) & (diff[WIDTH-1] != s1_a_q[WIDTH-1]);

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    illegal_d  = 1'b0;
    case (s1_ctrl_q)
      OP_ADD: begin
        result_d   = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = ovf_add;
      end
      OP_SUB: begin
        result_d   = diff[WIDTH-1:0];
        carry_d    = diff[WIDTH];
        overflow_d = ovf_sub;
      end
      OP_AND: result_d = s1_a_q & s1_b_q;
      OP_OR:  result_d = s1_a_q | s1_b_q;
      OP_SLT: begin
        result_d   = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
        carry_d    = diff[WIDTH];
        overflow_d = ovf_sub;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ctrl_q  <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_ctrl_q  <= in_ctrl;
        s1_tag_q   <= in_tag;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_carry_q    <= 1'b0;
      s2_overflow_q <= 1'b0;
      s2_zero_q     <= 1'b0;
      s2_negative_q <= 1'b0;
      s2_illegal_q  <= 1'b0;
      s2_tag_q      <= '0;
      op_count_q    <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid_q    <= 1'b1;
        s2_result_q   <= result_d;
        s2_carry_q    <= carry_d;
        s2_overflow_q <= overflow_d;
        s2_zero_q     <= (result_d == '0);
        s2_negative_q <= result_d[WIDTH-1];
        s2_illegal_q  <= illegal_d;
        s2_tag_q      <= s1_tag_q;
      end else if (pop) begin
        s2_valid_q <= 1'b0;
      end
      if (pop) begin
        op_count_q <= op_count_q + 1'b1;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_result_q;
  assign out_carry    = s2_carry_q;
  assign out_overflow = s2_overflow_q;
  assign out_zero     = s2_zero_q;
  assign out_negative = s2_negative_q;
  assign out_illegal  = s2_illegal_q;
  assign out_tag      = s2_tag_q;
  assign op_count     = op_count_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: queue-based reference model checked every cycle plus directed literal vectors.
module tb_alu_pipe;
  typedef struct packed {
    logic [31:0] r;
    logic        c, v, z, n, ill;
    logic [3:0]  tag;
  } resp_t;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_ctrl = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_carry, out_overflow, out_zero, out_negative, out_illegal;
  logic [3:0]  out_tag;
  logic [15:0] op_count;
  resp_t       dut_resp;

  int chk = 0, pass = 0;
  resp_t q[$];
  logic [15:0] cnt_m = '0;
  int cur_run = 0, best_run = 0;
  logic  held_v = 1'b0;
  resp_t held_r;

  alu_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_ctrl(in_ctrl), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero),
    .out_negative(out_negative), .out_illegal(out_illegal), .out_tag(out_tag),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  assign dut_resp = {out_result, out_carry, out_overflow, out_zero, out_negative, out_illegal, out_tag};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: signed/unsigned arithmetic on wide integers, no bit-level carry chains.
  function automatic resp_t model(input logic [31:0] a, b, input logic [2:0] c, input logic [3:0] t);
    resp_t  r;
    longint sa, sb, ss;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    r.tag = t;
    case (c)
      3'b000: begin
        u = {1'b0, a} + {1'b0, b};
        r.r = u[31:0]; r.c = u[32];
        ss = sa + sb; r.v = (ss > MAXS) || (ss < MINS);
      end
      3'b001: begin
        r.r = a - b; r.c = (a >= b);
        ss = sa - sb; r.v = (ss > MAXS) || (ss < MINS);
      end
      3'b010: r.r = a & b;
      3'b011: r.r = a | b;
      3'b101: begin
        r.r = (sa < sb) ? 32'd1 : 32'd0; r.c = (a >= b);
        ss = sa - sb; r.v = (ss > MAXS) || (ss < MINS);
      end
      default: r.ill = 1'b1;
    endcase
    r.z = (r.r == 32'd0);
    r.n = r.r[31];
    return r;
  endfunction

  function automatic resp_t mk(input logic [31:0] r, input logic c, v, z, n, ill, input logic [3:0] t);
    return {r, c, v, z, n, ill, t};
  endfunction

  // Monitor: handshakes evaluated at negedge, i.e. for the coming rising edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      cnt_m   = '0;
      held_v  = 1'b0;
      cur_run = 0;
    end else begin
      check("op_count", op_count, cnt_m);
      if (held_v && out_valid) check("stall_hold", dut_resp, held_r);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk++;
          $display("FAIL spurious_resp: got tag %h with no outstanding request", out_tag);
        end else begin
          check("resp", dut_resp, q[0]);
        end
        if (out_ready) begin
          $display("resp tag=%h result=%h C%0b V%0b Z%0b N%0b ill=%0b", out_tag, out_result,
                   out_carry, out_overflow, out_zero, out_negative, out_illegal);
          if (q.size() > 0) void'(q.pop_front());
          cnt_m = cnt_m + 16'd1;
        end
      end
      if (out_valid && out_ready) cur_run++;
      else if (!out_valid) cur_run = 0;
      if (cur_run > best_run) best_run = cur_run;
      held_v = out_valid && !out_ready;
      held_r = dut_resp;
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_ctrl, in_tag));
    end
  end

  task automatic send(input logic [31:0] a, b, input logic [2:0] c, input logic [3:0] t);
    bit acc;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_ctrl = c; in_tag = t;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      chk++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_ctrl = 3'($urandom); in_tag = 4'($urandom);
  endtask

  task automatic lit(input string nm, input logic [31:0] a, b, input logic [2:0] c,
                     input logic [3:0] t, input resp_t exp);
    int lat;
    check({nm, "_model"}, model(a, b, c, t), exp);
    send(a, b, c, t);
    idle();
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, lat, 2);
    check({nm, "_dut"}, dut_resp, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    check("reset_out_data", dut_resp, '0);
    check("reset_out_valid", out_valid, 0);
    check("reset_op_count", op_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    lit("add_1_1",     32'h1,        32'h1,        3'b000, 4'h3, mk(32'h2,        0, 0, 0, 0, 0, 4'h3));
    lit("add_ovf",     32'h7FFFFFFF, 32'h1,        3'b000, 4'h4, mk(32'h80000000, 0, 1, 0, 1, 0, 4'h4));
    lit("add_carry",   32'hFFFFFFFF, 32'h1,        3'b000, 4'h5, mk(32'h0,        1, 0, 1, 0, 0, 4'h5));
    lit("sub_1_1",     32'h1,        32'h1,        3'b001, 4'h6, mk(32'h0,        1, 0, 1, 0, 0, 4'h6));
    lit("sub_0_1",     32'h0,        32'h1,        3'b001, 4'h7, mk(32'hFFFFFFFF, 0, 0, 0, 1, 0, 4'h7));
    lit("sub_ovf",     32'h80000000, 32'h1,        3'b001, 4'h8, mk(32'h7FFFFFFF, 1, 1, 0, 0, 0, 4'h8));
    lit("slt_m1_1",    32'hFFFFFFFF, 32'h1,        3'b101, 4'h9, mk(32'h1,        1, 0, 0, 0, 0, 4'h9));
    lit("slt_1_m1",    32'h1,        32'hFFFFFFFF, 3'b101, 4'hA, mk(32'h0,        0, 0, 1, 0, 0, 4'hA));
    lit("and",         32'h0000F0F0, 32'h0000FF00, 3'b010, 4'hB, mk(32'h0000F000, 0, 0, 0, 0, 0, 4'hB));
    lit("or",          32'h0000000F, 32'h000000F0, 3'b011, 4'hC, mk(32'h000000FF, 0, 0, 0, 0, 0, 4'hC));
    lit("illegal_111", 32'h12345678, 32'h9,        3'b111, 4'hD, mk(32'h0,        0, 0, 1, 0, 1, 4'hD));

    // Reset with two ops in flight under backpressure.
    out_ready = 1'b0;
    send(32'h10, 32'h20, 3'b000, 4'h1);
    send(32'h30, 32'h40, 3'b001, 4'h2);
    idle();
    #2 reset = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_op_count", op_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("postreset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    lit("postreset_add", 32'h5, 32'h6, 3'b000, 4'hE, mk(32'hB, 0, 0, 0, 0, 0, 4'hE));

    // Eight back-to-back ops at full downstream readiness.
    best_run = 0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ops [4];
      ops = '{3'b000, 3'b001, 3'b101, 3'b011};
      send(32'h11111111 * i, 32'h9 - i, ops[i % 4], 4'(i));
    end
    idle();
    repeat (6) @(posedge clk);
    #1;
    check("b2b_consecutive", best_run, 8);
    check("b2b_op_count", op_count, 9);

    // Backpressure: in_ready must drop after two accepts and nothing may be lost.
    out_ready = 1'b0;
    send(32'hA, 32'h3, 3'b001, 4'h1);
    send(32'hC, 32'h5, 3'b010, 4'h2);
    in_valid = 1'b1; in_a = 32'h80000000; in_b = 32'h80000000; in_ctrl = 3'b000; in_tag = 4'h3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h80000000, 32'h80000000, 3'b000, 4'h3);
    idle();
    repeat (6) @(posedge clk);
    #1;
    check("stall_op_count", op_count, 12);
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
